// File: rtl/dtw_pkg.sv
// dtw_pkg: shared constants for the DTW reference store and its consumers.
// Holds op-mode codes, FSM state encodings and block version fields.
package dtw_pkg;

    localparam logic MODE_DTW_READ = 1'b0;
    localparam logic MODE_LOAD_REF = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;

    localparam logic [7:0] DTW_REF_VER_MAJOR = 8'd2;
    localparam logic [7:0] DTW_REF_VER_MINOR = 8'd0;

endpackage

// File: rtl/dtw_ref_bank.sv
// dtw_ref_bank: single-write / single-read synchronous RAM, one read cycle.
// Ports: clk/rst_n, write (we, waddr, wdata), read (re, raddr) -> rdata.
import dtw_pkg::*;

module dtw_ref_bank #(
    parameter int width      = 16,
    parameter int ptrWid     = 20,
    parameter int initalize  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ptrWid-1:0] waddr,
    input  logic [width-1:0]  wdata,
    input  logic              re,
    input  logic [ptrWid-1:0] raddr,
    output logic [width-1:0]  rdata
);

    logic [width-1:0] mem [2**ptrWid];
    logic [width-1:0] rdata_q;
    logic [width-1:0] rdata_d;

    if (initalize != 0) begin : g_preload
        // Preloaded image is placed into mem by the simulation harness
        // through hierarchical access; the array itself is never reset.
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value when no read is issued.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dtw_core_ref_mc.sv
// dtw_core_ref_mc: loads one reference from the FWFT source FIFO into
// NUM_RD_PORTS replicated banks and serves independent 1-cycle read ports.
// Ports: clk_in/rst_n_in; rs_in, op_mode_in, ref_clear_in, ref_len_in;
// busy/done/word-count status; src_fifo_* source; rd_* per-port reads; dbg.
import dtw_pkg::*;

module dtw_core_ref_mc #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 32,
    parameter int REFMEM_PTR_WIDTH = 20,
    parameter int NUM_RD_PORTS     = 4,
    parameter int REF_INIT         = 0
) (
    input  logic                                   clk_in,
    input  logic                                   rst_n_in,
    input  logic                                   rs_in,
    input  logic                                   op_mode_in,
    input  logic                                   ref_clear_in,
    input  logic [ADDR_WIDTH-1:0]                  ref_len_in,
    output logic                                   busy_out,
    output logic                                   ref_load_done_out,
    output logic [ADDR_WIDTH-1:0]                  ref_words_out,
    output logic                                   src_fifo_clear_out,
    output logic                                   src_fifo_rden_out,
    input  logic                                   src_fifo_empty_in,
    input  logic [DATA_WIDTH-1:0]                  src_fifo_data_in,
    input  logic [NUM_RD_PORTS-1:0]                rd_en_in,
    input  logic [NUM_RD_PORTS*REFMEM_PTR_WIDTH-1:0] rd_addr_in,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     rd_data_out,
    output logic [NUM_RD_PORTS-1:0]                rd_valid_out,
    output logic [1:0]                             dbg_state_out
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam int PW = REFMEM_PTR_WIDTH;
    localparam logic [LW-1:0] DEPTH = LW'(1) << PW;

    logic [1:0]              state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   words_q, words_d;
    logic [LW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]           len_q, len_d;
    logic [NUM_RD_PORTS-1:0] rd_valid_q, rd_valid_d;

    logic [LW-1:0] len_ext;
    logic [LW-1:0] eff_len;
    logic          pop;
    logic          rd_ok;

    // Length clamped to bank depth; one extra bit so a full bank fits.
    assign len_ext = {1'b0, ref_len_in};
    assign eff_len = (len_ext > DEPTH) ? DEPTH : len_ext;

    assign pop   = (state_q == ST_LOAD) && !src_fifo_empty_in
                   && (wr_ptr_q < len_q);
    assign rd_ok = (state_q == ST_READ) && done_q;

    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        words_d    = words_q;
        wr_ptr_d   = wr_ptr_q;
        len_d      = len_q;
        busy_d     = (state_q != ST_IDLE);
        rd_valid_d = rd_en_in & {NUM_RD_PORTS{rd_ok}};

        unique case (state_q)
            ST_IDLE, ST_READ: begin
                if (ref_clear_in) begin
                    done_d  = 1'b0;
                    words_d = '0;
                end
                if (!rs_in) begin
                    state_d = ST_IDLE;
                end else if (op_mode_in == MODE_DTW_READ) begin
                    state_d = ST_READ;
                end else if (!done_q && !ref_clear_in) begin
                    // A clear in the same cycle defers the load by one cycle.
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                    len_d    = eff_len;
                    words_d  = '0;
                end
            end
            ST_LOAD: begin
                if (pop) begin
                    wr_ptr_d = wr_ptr_q + LW'(1);
                    words_d  = words_q + ADDR_WIDTH'(1);
                end
                if (!rs_in) begin
                    state_d = ST_IDLE;
                end else if (wr_ptr_d == len_q) begin
                    // Covers both the final pop and a zero-length load.
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            words_q    <= '0;
            wr_ptr_q   <= '0;
            len_q      <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            words_q    <= words_d;
            wr_ptr_q   <= wr_ptr_d;
            len_q      <= len_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_bank
        dtw_ref_bank #(
            .width     (DATA_WIDTH),
            .ptrWid    (PW),
            .initalize (REF_INIT)
        ) u_bank (
            .clk   (clk_in),
            .rst_n (rst_n_in),
            .we    (pop),
            .waddr (wr_ptr_q[PW-1:0]),
            .wdata (src_fifo_data_in),
            .re    (rd_en_in[k] & rd_ok),
            .raddr (rd_addr_in[k*PW +: PW]),
            .rdata (rd_data_out[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign busy_out           = busy_q;
    assign ref_load_done_out  = done_q;
    assign ref_words_out      = words_q;
    assign src_fifo_clear_out = (state_q == ST_IDLE);
    assign src_fifo_rden_out  = pop;
    assign rd_valid_out       = rd_valid_q;
    assign dbg_state_out      = state_q;

endmodule
